// File: rtl/booth_mul_arbiter_if.sv
// Requester and multiplier signal bundle for booth_mul_arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface booth_mul_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [15:0]    rsp_result;
  logic           rsp_err;
  logic           mul_enable;
  logic [7:0]     mul_inbus;
  logic           mul_done;
  logic [7:0]     mul_outbus;
  logic           busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_outbus,
    output req_ready, rsp_valid, rsp_result, rsp_err, mul_enable, mul_inbus, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_done, mul_outbus,
    input  req_ready, rsp_valid, rsp_result, rsp_err, mul_enable, mul_inbus, busy
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin scheduler sharing one 8x8 signed Booth multiplier among N requesters,
// with a watchdog that aborts an operation whose done never arrives.
module booth_mul_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  booth_mul_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_M  = 3'd1,
    S_LOAD_Q  = 3'd2,
    S_WAIT    = 3'd3,
    S_READ_LO = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_rr;
  logic [IW-1:0] r_g;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_b;
  logic [7:0]    r_hi;
  logic          r_mul_enable;
  logic [7:0]    r_mul_inbus;
  logic [N-1:0]  r_rsp_valid;
  logic [15:0]   r_rsp_result;
  logic          r_rsp_err;
  logic          r_busy;

  logic          w_any;
  logic [IW-1:0] w_idx;
  logic [IW:0]   w_j;
  logic [IW-1:0] w_next_rr;
  logic [N-1:0]  w_g_onehot;

  // Grant search: first valid requester at or above the pointer, wrapping past N-1.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j   = {1'b0, r_rr} + (IW+1)'(k);
      w_j   = (w_j >= (IW+1)'(N)) ? w_j - (IW+1)'(N) : w_j;
      w_any = w_any | bus.req_valid[w_j[IW-1:0]];
      w_idx = bus.req_valid[w_j[IW-1:0]] ? w_j[IW-1:0] : w_idx;
    end
  end

  assign w_next_rr  = (r_g == IW'(N - 1)) ? '0 : r_g + IW'(1);
  assign w_g_onehot = N'(1) << r_g;

  // Accept strobe is gated by rst_n so a reset edge never doubles as an accept.
  assign bus.req_ready  = (rst_n && (r_state == S_IDLE) && w_any) ? (N'(1) << w_idx) : '0;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.mul_enable = r_mul_enable;
  assign bus.mul_inbus  = r_mul_inbus;
  assign bus.busy       = r_busy;

  // Control FSM; every output register is set on the edge that enters its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rr         <= '0;
      r_g          <= '0;
      r_cnt        <= '0;
      r_b          <= 8'h00;
      r_hi         <= 8'h00;
      r_mul_enable <= 1'b0;
      r_mul_inbus  <= 8'h00;
      r_rsp_valid  <= '0;
      r_rsp_result <= 16'h0000;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_g          <= w_idx;
            r_b          <= bus.req_b[{w_idx, 3'b000} +: 8];
            r_mul_inbus  <= bus.req_a[{w_idx, 3'b000} +: 8];
            r_mul_enable <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_LOAD_M;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD_M: begin
          r_mul_inbus <= r_b;
          r_state     <= S_LOAD_Q;
        end
        S_LOAD_Q: begin
          r_mul_inbus <= 8'h00;
          r_cnt       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_done) begin
            r_hi    <= bus.mul_outbus;
            r_state <= S_READ_LO;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rsp_result <= 16'h0000;
            r_rsp_err    <= 1'b1;
            r_mul_enable <= 1'b0;
            r_rsp_valid  <= w_g_onehot;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_READ_LO: begin
          r_rsp_result <= {r_hi, bus.mul_outbus};
          r_rsp_err    <= 1'b0;
          r_mul_enable <= 1'b0;
          r_rsp_valid  <= w_g_onehot;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready[r_g]) begin
            r_rsp_valid <= '0;
            r_rr        <= w_next_rr;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_RESP;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_mul_enable <= 1'b0;
          r_rsp_valid  <= '0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter: directed table, corner sequences and
// randomized rounds against a round-robin/product reference model.
module tb_booth_mul_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  booth_mul_arbiter_if #(.N(N)) bus ();
  booth_mul_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int         n_tests = 0;
  int         n_fail  = 0;
  int         mdl_delay = 5;   // done after this many WAIT cycles; <= 0 never answers
  int         spur_cnt  = 0;   // negedges on which a spurious done is forced
  logic [7:0] mdl_m = 8'h00;
  logic [7:0] mdl_q = 8'h00;
  int         ref_ptr = 0;

  typedef struct {
    int          req;
    logic [7:0]  a;
    logic [7:0]  b;
    int          delay;
    int          hold;
    logic [15:0] exp_res;
    logic        exp_err;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int ref_grant(input logic [N-1:0] m, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[15:0];
  endfunction

  // Behavioural multiplier: takes M on enable rise, Q next cycle, answers hi then lo.
  initial begin : mul_model
    int         phase;
    int         cnt;
    int         p;
    logic       prev_en;
    logic [15:0] prod;
    phase = 0; cnt = 0; p = 0; prev_en = 1'b0; prod = 16'h0000;
    bus.mul_done = 1'b0;
    bus.mul_outbus = 8'h00;
    forever begin
      @(negedge clk);
      bus.mul_done = 1'b0;
      bus.mul_outbus = 8'h00;
      if (bus.mul_enable !== 1'b1) begin
        phase = 0;
      end else if (!prev_en) begin
        mdl_m = bus.mul_inbus;
        phase = 1;
      end else if (phase == 1) begin
        mdl_q = bus.mul_inbus;
        p = $signed(mdl_m) * $signed(mdl_q);
        prod = p[15:0];
        cnt = 0;
        phase = 2;
      end else if (phase == 2) begin
        cnt++;
        if (mdl_delay > 0 && cnt == mdl_delay) begin
          bus.mul_done = 1'b1;
          bus.mul_outbus = prod[15:8];
          phase = 3;
        end
      end else if (phase == 3) begin
        bus.mul_done = 1'b1;
        bus.mul_outbus = prod[7:0];
        phase = 4;
      end
      prev_en = (bus.mul_enable === 1'b1);
      if (spur_cnt > 0) begin
        spur_cnt--;
        bus.mul_done = 1'b1;
        bus.mul_outbus = 8'h5A;
      end
    end
  end

  // One full operation: offer mask, expect grant exp_g, check response and release it.
  task automatic transact(input logic [N-1:0] mask, input logic [8*N-1:0] av,
                          input logic [8*N-1:0] bv, input int delay, input int hold,
                          input int exp_g, input logic [15:0] exp_res, input logic exp_err,
                          input string tag);
    int          n;
    logic [N-1:0] oh;
    oh = N'(1) << exp_g;
    mdl_delay = delay;
    bus.req_a = av;
    bus.req_b = bv;
    bus.req_valid = mask;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " accept"}, 32'(bus.req_ready), 32'(oh));
    tick();
    bus.req_valid = '0;
    check({tag, " busy"}, 32'(bus.busy), 32'h1);
    n = 1;
    while (bus.rsp_valid == '0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'((delay > 0) ? 4 + delay : 3 + TIMEOUT));
    check({tag, " inbus M/Q"}, 32'({mdl_m, mdl_q}), 32'({av[8*exp_g +: 8], bv[8*exp_g +: 8]}));
    check({tag, " rsp"}, 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_result}),
          32'({oh, exp_err, exp_res}));
    check({tag, " enable off"}, 32'(bus.mul_enable), 32'h0);
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = N'(1) << ((exp_g + 1) % N);
      #1;
      check({tag, " no accept in resp"}, 32'(bus.req_ready), 32'h0);
      tick();
      check({tag, " hold"}, 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_result}),
            32'({oh, exp_err, exp_res}));
    end
    bus.req_valid = '0;
    bus.rsp_ready = ~oh;
    tick();
    check({tag, " other ready ignored"}, 32'(bus.rsp_valid), 32'(oh));
    bus.rsp_ready = oh;
    tick();
    bus.rsp_ready = '0;
    check({tag, " release"}, 32'({bus.rsp_valid, bus.busy}), 32'h0);
    ref_ptr = (exp_g + 1) % N;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [8*N-1:0] av;
    logic [8*N-1:0] bv;
    logic [N-1:0]   m;
    int             g;
    int             n;
    int             ord[6];

    vecs[0] = '{req: 0, a: 8'h07, b: 8'hFD, delay: 5, hold: 0,  exp_res: 16'hFFEB, exp_err: 1'b0};
    vecs[1] = '{req: 1, a: 8'h7F, b: 8'h7F, delay: 2, hold: 0,  exp_res: 16'h3F01, exp_err: 1'b0};
    vecs[2] = '{req: 2, a: 8'h80, b: 8'h80, delay: 3, hold: 10, exp_res: 16'h4000, exp_err: 1'b0};
    vecs[3] = '{req: 3, a: 8'h80, b: 8'h7F, delay: 1, hold: 0,  exp_res: 16'hC080, exp_err: 1'b0};
    vecs[4] = '{req: 1, a: 8'h11, b: 8'h22, delay: -1, hold: 1, exp_res: 16'h0000, exp_err: 1'b1};
    vecs[5] = '{req: 0, a: 8'hFF, b: 8'hFF, delay: 6, hold: 0,  exp_res: 16'h0001, exp_err: 1'b0};
    vecs[6] = '{req: 2, a: 8'h01, b: 8'h80, delay: 2, hold: 0,  exp_res: 16'hFF80, exp_err: 1'b0};
    vecs[7] = '{req: 3, a: 8'h12, b: 8'h34, delay: 1, hold: 2,  exp_res: 16'h03A8, exp_err: 1'b0};
    ord = '{0, 1, 2, 3, 0, 1};

    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    tick();
    tick();
    check("reset ctrl", 32'({bus.rsp_valid, bus.req_ready, bus.busy, bus.mul_enable,
                             bus.rsp_err, bus.mul_inbus}), 32'h0);
    check("reset result", 32'(bus.rsp_result), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      av = {N{8'hCC}};
      bv = {N{8'h33}};
      av[8*vecs[i].req +: 8] = vecs[i].a;
      bv[8*vecs[i].req +: 8] = vecs[i].b;
      m = N'(1) << vecs[i].req;
      transact(m, av, bv, vecs[i].delay, vecs[i].hold, vecs[i].req,
               vecs[i].exp_res, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // All requesters pending: grants must rotate from pointer 0.
    for (int k = 0; k < 6; k++) begin
      av = {$urandom, $urandom} >> (64 - 8 * N);
      bv = {$urandom, $urandom} >> (64 - 8 * N);
      g = ord[k];
      transact({N{1'b1}}, av, bv, 2, 0, g, ref_mul(av[8*g +: 8], bv[8*g +: 8]), 1'b0,
               $sformatf("fair%0d", k));
    end

    // Timeout with everyone pending, then service continues with the next requester.
    av = {N{8'h21}};
    bv = {N{8'h43}};
    g = ref_grant({N{1'b1}}, ref_ptr);
    transact({N{1'b1}}, av, bv, -1, 0, g, 16'h0000, 1'b1, "tmo");
    g = ref_grant({N{1'b1}}, ref_ptr);
    transact({N{1'b1}}, av, bv, 3, 0, g, ref_mul(8'h21, 8'h43), 1'b0, "after tmo");

    // Spurious done in IDLE, then across IDLE/LOAD_M/LOAD_Q of a real operation.
    spur_cnt = 2;
    repeat (3) tick();
    check("spur idle", 32'({bus.rsp_valid, bus.busy, bus.mul_enable}), 32'h0);
    spur_cnt = 3;
    av = {N{8'hF6}};
    bv = {N{8'h0C}};
    transact(4'b0001, av, bv, 4, 0, 0, ref_mul(8'hF6, 8'h0C), 1'b0, "spur op");

    // Reset during WAIT drops the operation and returns the pointer to 0.
    transact(4'b0010, av, bv, 1, 0, 1, ref_mul(8'hF6, 8'h0C), 1'b0, "pre rst");
    mdl_delay = -1;
    bus.req_a = {N{8'h44}};
    bus.req_b = {N{8'h55}};
    bus.req_valid = 4'b0100;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    check("rst inflight accept", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    check("mid rst ctrl", 32'({bus.rsp_valid, bus.req_ready, bus.busy, bus.mul_enable,
                               bus.rsp_err, bus.mul_inbus}), 32'h0);
    check("mid rst result", 32'(bus.rsp_result), 32'h0);
    rst_n = 1'b1;
    ref_ptr = 0;
    repeat (3) tick();
    check("post rst quiet", 32'({bus.rsp_valid, bus.busy}), 32'h0);
    av = {N{8'h0B}};
    bv = {N{8'hF9}};
    g = ref_grant(4'b1010, ref_ptr);
    transact(4'b1010, av, bv, 3, 0, g, ref_mul(8'h0B, 8'hF9), 1'b0, "post rst");

    // Randomized rounds against the reference model.
    for (int r = 0; r < 24; r++) begin
      m  = N'($urandom_range(1, (1 << N) - 1));
      av = {$urandom, $urandom} >> (64 - 8 * N);
      bv = {$urandom, $urandom} >> (64 - 8 * N);
      g  = ref_grant(m, ref_ptr);
      transact(m, av, bv, $urandom_range(1, 6), $urandom_range(0, 2), g,
               ref_mul(av[8*g +: 8], bv[8*g +: 8]), 1'b0, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
